pixel_write_arbiter: RTL and testbench

//  Shares the single framebuffer pixel write port between the processor and the grid-draw engine.

---
 rtl/pixel_write_arbiter.sv | 138 +++++++++++++
 tb/tb_pixel_write_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_write_arbiter.sv
// Purpose: merges buffered processor pixel writes and engine req/gnt writes onto one framebuffer write port.
// Latency: a CPU write is eligible one edge after its push; an engine grant appears on fb the edge it is taken.
// Backpressure: fb_we && !fb_ready freezes the output stage, stops pops and grants; CPU writes to a full FIFO drop.
module pixel_write_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cpu_pixel_en,
    input  logic [ADDR_W-1:0]               cpu_pixel_addr,
    input  logic                            cpu_pixel_value,
    output logic                            cpu_overflow,
    input  logic                            eng_req,
    input  logic [ADDR_W-1:0]               eng_addr,
    input  logic                            eng_value,
    output logic                            eng_gnt,
    output logic                            fb_we,
    output logic [ADDR_W-1:0]               fb_addr,
    output logic                            fb_data,
    input  logic                            fb_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH+1);
    localparam int SW = $clog2(STARVE_MAX+1);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              value;
    } pix_t;

    pix_t            r_mem [FIFO_DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [SW-1:0]   r_starve;
    logic            r_overflow;
    logic            r_fb_we;
    logic [ADDR_W-1:0] r_fb_addr;
    logic            r_fb_data;

    logic            w_free;
    logic            w_empty;
    logic            w_full;
    logic            w_starved;
    logic            w_eng_sel;
    logic            w_pop;
    logic            w_push;
    pix_t            w_head;
    pix_t            w_cpu_wr;

    assign w_free    = !r_fb_we || fb_ready;
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CW'(FIFO_DEPTH));
    assign w_starved = (r_starve == SW'(STARVE_MAX));
    // The engine wins only when the FIFO has nothing, or it has waited long enough.
    assign w_eng_sel = w_free && eng_req && (w_empty || w_starved);
    assign w_pop     = w_free && !w_empty && !w_eng_sel;
    // A full FIFO still accepts a push when its head leaves on the same edge.
    assign w_push    = cpu_pixel_en && (!w_full || w_pop);
    assign w_head    = r_mem[r_rd_ptr];
    assign w_cpu_wr  = '{addr: cpu_pixel_addr, value: cpu_pixel_value};

    assign eng_gnt      = w_eng_sel;
    assign cpu_overflow = r_overflow;
    assign fb_we        = r_fb_we;
    assign fb_addr      = r_fb_addr;
    assign fb_data      = r_fb_data;
    assign fifo_count   = r_count;

    // FIFO storage; contents are don't-care until the count says otherwise, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_cpu_wr;
        end
    end

    // FIFO pointers, exact occupancy and sticky drop flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
            if (cpu_pixel_en && !w_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Starvation counter: counts CPU wins while the engine waits, cleared on grant or idle engine.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_starve <= '0;
        end else if (w_eng_sel || !eng_req) begin
            r_starve <= '0;
        end else if (w_pop && !w_starved) begin
            r_starve <= r_starve + SW'(1);
        end
    end

    // Registered output stage: loads only when free; address/data hold when nothing is selected.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fb_we   <= 1'b0;
            r_fb_addr <= '0;
            r_fb_data <= 1'b0;
        end else if (w_free) begin
            if (w_eng_sel) begin
                r_fb_we   <= 1'b1;
                r_fb_addr <= eng_addr;
                r_fb_data <= eng_value;
            end else if (w_pop) begin
                r_fb_we   <= 1'b1;
                r_fb_addr <= w_head.addr;
                r_fb_data <= w_head.value;
            end else begin
                r_fb_we   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Purpose: directed-vector bench for pixel_write_arbiter with hand-computed expectations.
// Latency: inputs change 1 time unit after a rising edge; outputs are sampled there too.
// Backpressure: fb_ready is driven directly by the vectors to exercise stall and drop paths.
module tb_pixel_write_arbiter;

    localparam int ADDR_W = 32;

    logic              clk;
    logic              rst;
    logic              cpu_pixel_en;
    logic [ADDR_W-1:0] cpu_pixel_addr;
    logic              cpu_pixel_value;
    logic              cpu_overflow;
    logic              eng_req;
    logic [ADDR_W-1:0] eng_addr;
    logic              eng_value;
    logic              eng_gnt;
    logic              fb_we;
    logic [ADDR_W-1:0] fb_addr;
    logic              fb_data;
    logic              fb_ready;
    logic [2:0]        fifo_count;

    int n_vec;
    int n_err;

    pixel_write_arbiter #(.ADDR_W(ADDR_W), .FIFO_DEPTH(4), .STARVE_MAX(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .cpu_pixel_en    (cpu_pixel_en),
        .cpu_pixel_addr  (cpu_pixel_addr),
        .cpu_pixel_value (cpu_pixel_value),
        .cpu_overflow    (cpu_overflow),
        .eng_req         (eng_req),
        .eng_addr        (eng_addr),
        .eng_value       (eng_value),
        .eng_gnt         (eng_gnt),
        .fb_we           (fb_we),
        .fb_addr         (fb_addr),
        .fb_data         (fb_data),
        .fb_ready        (fb_ready),
        .fifo_count      (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply reset between clock edges and release it before the next edge.
    task automatic do_reset();
        cpu_pixel_en = 1'b0;
        eng_req      = 1'b0;
        rst          = 1'b0;
        #2;
        rst          = 1'b1;
        tick();
    endtask

    task automatic cpu_drive(input logic [ADDR_W-1:0] a, input logic v);
        cpu_pixel_en    = 1'b1;
        cpu_pixel_addr  = a;
        cpu_pixel_value = v;
    endtask

    logic [ADDR_W-1:0] exp_a [4];
    logic              exp_d [4];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b0;
        cpu_pixel_en = 1'b0; cpu_pixel_addr = '0; cpu_pixel_value = 1'b0;
        eng_req = 1'b0; eng_addr = '0; eng_value = 1'b0;
        fb_ready = 1'b1;
        #13;
        check("rst_fb_we",   fb_we, 0);
        check("rst_fb_addr", fb_addr, 0);
        check("rst_fb_data", fb_data, 0);
        check("rst_count",   fifo_count, 0);
        check("rst_ovf",     cpu_overflow, 0);
        check("rst_gnt",     eng_gnt, 0);
        rst = 1'b1;
        tick();

        // Single CPU write, fb always ready.
        fb_ready = 1'b1;
        cpu_drive(32'h10, 1'b1);
        tick();
        cpu_pixel_en = 1'b0;
        check("t1_count_push", fifo_count, 1);
        check("t1_we_early",   fb_we, 0);
        tick();
        check("t1_we",    fb_we, 1);
        check("t1_addr",  fb_addr, 32'h10);
        check("t1_data",  fb_data, 1);
        check("t1_count", fifo_count, 0);
        tick();
        check("t1_we_off",   fb_we, 0);
        check("t1_addr_hold", fb_addr, 32'h10);

        // Fill under backpressure: first write parks in the output stage, four fill the FIFO.
        do_reset();
        fb_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cpu_drive(32'h20 + i, i[0]);
            tick();
        end
        cpu_pixel_en = 1'b0;
        check("t2_count_full", fifo_count, 4);
        check("t2_ovf_none",   cpu_overflow, 0);
        check("t2_we_hold",    fb_we, 1);
        check("t2_addr_hold",  fb_addr, 32'h20);
        check("t2_data_hold",  fb_data, 0);

        // Full FIFO with simultaneous pop and push: no drop.
        fb_ready = 1'b1;
        cpu_drive(32'h30, 1'b1);
        tick();
        cpu_pixel_en = 1'b0;
        fb_ready = 1'b0;
        check("t3_count",  fifo_count, 4);
        check("t3_ovf",    cpu_overflow, 0);
        check("t3_addr",   fb_addr, 32'h21);
        check("t3_data",   fb_data, 1);

        // Full FIFO, stalled output: write is dropped and the flag sticks.
        cpu_drive(32'h31, 1'b0);
        tick();
        cpu_pixel_en = 1'b0;
        check("t2_ovf_set",   cpu_overflow, 1);
        check("t2_count_stay", fifo_count, 4);
        check("t2_addr_stall", fb_addr, 32'h21);
        check("t2_we_stall",   fb_we, 1);

        // Drain preserves push order; the dropped 0x31 never appears.
        exp_a = '{32'h22, 32'h23, 32'h24, 32'h30};
        exp_d = '{1'b0, 1'b1, 1'b0, 1'b1};
        fb_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t3_drain_addr",  fb_addr, exp_a[i]);
            check("t3_drain_data",  fb_data, exp_d[i]);
            check("t3_drain_count", fifo_count, 64'(3 - i));
        end
        tick();
        check("t3_drain_idle", fb_we, 0);
        check("t3_ovf_sticky", cpu_overflow, 1);

        // Starvation: engine waits through 8 CPU wins then is forced a grant.
        do_reset();
        fb_ready = 1'b1;
        cpu_drive(32'h40, 1'b0);
        tick();
        eng_req   = 1'b1;
        eng_addr  = 32'hE0;
        eng_value = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cpu_drive(32'h41 + k, 1'b0);
            #1;
            check("t4_gnt_low", eng_gnt, 0);
            tick();
            check("t4_cpu_addr", fb_addr, 32'h40 + k);
        end
        cpu_drive(32'h49, 1'b0);
        #1;
        check("t4_gnt_forced", eng_gnt, 1);
        tick();
        check("t4_eng_addr", fb_addr, 32'hE0);
        check("t4_eng_data", fb_data, 1);
        check("t4_count",    fifo_count, 2);
        cpu_pixel_en = 1'b0;
        eng_req = 1'b0;
        #1;
        check("t4_gnt_idle", eng_gnt, 0);
        tick();
        check("t4_after_addr", fb_addr, 32'h48);
        eng_req  = 1'b1;
        eng_addr = 32'hE1;
        #1;
        check("t4_restart_gnt", eng_gnt, 0);
        tick();
        check("t4_restart_addr", fb_addr, 32'h49);
        #1;
        check("t4_empty_gnt", eng_gnt, 1);
        tick();
        check("t4_e1_addr", fb_addr, 32'hE1);
        eng_req = 1'b0;

        // Engine alone with fb_ready toggling.
        do_reset();
        fb_ready  = 1'b0;
        eng_req   = 1'b1;
        eng_addr  = 32'hA5;
        eng_value = 1'b0;
        #1;
        check("t5_gnt_free", eng_gnt, 1);
        tick();
        check("t5_addr0", fb_addr, 32'hA5);
        check("t5_we0",   fb_we, 1);
        eng_addr  = 32'hA6;
        eng_value = 1'b1;
        #1;
        check("t5_gnt_stall", eng_gnt, 0);
        tick();
        check("t5_addr_hold", fb_addr, 32'hA5);
        check("t5_data_hold", fb_data, 0);
        fb_ready = 1'b1;
        #1;
        check("t5_gnt_ready", eng_gnt, 1);
        tick();
        check("t5_addr1", fb_addr, 32'hA6);
        check("t5_data1", fb_data, 1);
        fb_ready = 1'b0;
        eng_req  = 1'b0;
        tick();
        check("t5_we_hold1", fb_we, 1);
        fb_ready = 1'b1;
        tick();
        check("t5_we_done", fb_we, 0);
        check("t5_addr_kept", fb_addr, 32'hA6);

        // Asynchronous reset mid-operation.
        do_reset();
        fb_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cpu_drive(32'h60 + i, 1'b1);
            tick();
        end
        cpu_pixel_en = 1'b0;
        check("t6_pre_we",    fb_we, 1);
        check("t6_pre_count", fifo_count, 3);
        #2;
        rst = 1'b0;
        #1;
        check("t6_async_we",    fb_we, 0);
        check("t6_async_count", fifo_count, 0);
        check("t6_async_addr",  fb_addr, 0);
        #1;
        rst = 1'b1;
        fb_ready = 1'b1;
        tick();
        tick();
        check("t6_post_we", fb_we, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
